// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with address decode.
// Shares one single-transaction memory bus between NUM_MASTERS requesters and
// NUM_SLAVES slaves. One winning command is latched and routed to the slave
// selected by addr[15:12]. The winner receives a one-cycle m_ready pulse with
// the read data and an error flag. Unmapped addresses, illegal commands and
// stalled slaves all complete with m_err set.
module bus_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned NUM_SLAVES  = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // master side
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  // slave side
  output logic [NUM_SLAVES-1:0]         s_valid,
  output logic                          s_read,
  output logic                          s_write,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [NUM_SLAVES-1:0]         s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata,
  // status
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          busy
);

  localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [MW-1:0]   ptr;        // last winner; search starts just above it
  logic [MW-1:0]   win_q;      // owner of the transaction in flight
  logic [SW-1:0]   sel_q;      // decoded slave index
  logic            dec_err_q;  // command rejected at latch time
  logic [CW-1:0]   cnt;        // cycles spent waiting for s_ready

  // arbitration signals
  logic [MW-1:0]     win_idx;
  logic              win_found;
  int unsigned       cand;

  // winner's command slices and decode
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_read;
  logic              win_write;
  logic [3:0]        win_region;
  logic              win_dec_err;

  // selected slave response
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;

  // completion decision for the current XFER cycle
  logic              resp_fire;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  // Rotating priority search: first requester above the pointer, wrapping.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = (32'(ptr) + k) % NUM_MASTERS;
      if (!win_found && m_valid[MW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = MW'(cand);
      end
    end
  end

  assign win_addr   = m_addr[win_idx*ADDR_W +: ADDR_W];
  assign win_wdata  = m_wdata[win_idx*DATA_W +: DATA_W];
  assign win_read   = m_read[win_idx];
  assign win_write  = m_write[win_idx];
  assign win_region = win_addr[15:12];

  // Unmapped region or a command that is not exactly one of read/write.
  assign win_dec_err = (32'(win_region) >= NUM_SLAVES) || (win_read == win_write);

  assign sel_ready = s_ready[sel_q];
  assign sel_rdata = s_rdata[sel_q*DATA_W +: DATA_W];

  // Decide whether the transaction completes this cycle and with what result.
  always_comb begin
    resp_fire = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    if (state == XFER) begin
      if (dec_err_q) begin
        resp_fire = 1'b1;
        resp_err  = 1'b1;
      end else if (sel_ready) begin
        resp_fire = 1'b1;
        resp_data = s_read ? sel_rdata : '0;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        resp_fire = 1'b1;
        resp_err  = 1'b1;
      end
    end
  end

  // Transaction FSM with all bus outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= MW'(NUM_MASTERS - 1);
      win_q     <= '0;
      sel_q     <= '0;
      dec_err_q <= 1'b0;
      cnt       <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      s_valid   <= '0;
      s_read    <= 1'b0;
      s_write   <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      m_ready   <= '0;
      m_rdata   <= '0;
      m_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= XFER;
            busy      <= 1'b1;
            win_q     <= win_idx;
            grant     <= NUM_MASTERS'(1) << win_idx;
            s_read    <= win_read;
            s_write   <= win_write;
            s_addr    <= win_addr;
            s_wdata   <= win_wdata;
            sel_q     <= SW'(win_region);
            dec_err_q <= win_dec_err;
            cnt       <= '0;
            s_valid   <= win_dec_err ? '0 : (NUM_SLAVES'(1) << SW'(win_region));
          end
        end
        XFER: begin
          if (resp_fire) begin
            state   <= RESP;
            s_valid <= '0;
            m_ready <= grant;
            m_rdata <= resp_data;
            m_err   <= resp_err;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state   <= IDLE;
          m_ready <= '0;
          ptr     <= win_q;
          cnt     <= '0;
          grant   <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Testbench for bus_rr_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_bus_rr_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned NS = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM-1:0]    m_valid, m_read, m_write, m_ready;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata;
  logic             m_err;
  logic [NS-1:0]    s_valid, s_ready;
  logic             s_read, s_write;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NM-1:0]    grant;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_read(m_read), .m_write(m_write),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_valid(s_valid), .s_read(s_read), .s_write(s_write),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  task automatic clear_inputs();
    m_valid = '0; m_read = '0; m_write = '0; m_addr = '0; m_wdata = '0;
    s_ready = '0; s_rdata = '0;
  endtask

  // Reset pulse; returns at a negedge with reset released and the bus idle.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    m_valid = '1; m_read = '1;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_ready, grant, busy, s_valid} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 0", {m_ready, grant, busy, s_valid});
    end
    checks++;
    if ({m_rdata, m_err, s_read, s_write, s_addr, s_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {m_rdata, m_err, s_read, s_write, s_addr, s_wdata});
    end
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    m_valid = 4'b0001; m_read = 4'b0001; m_addr[0 +: AW] = 16'h0010;
    @(negedge clk);
    checks++;
    if ({grant, s_valid, s_read, s_write, s_addr, busy} !== {4'b0001, 2'b01, 1'b1, 1'b0, 16'h0010, 1'b1}) begin
      errors++;
      $display("FAIL read_issue: got %h expected %h", {grant, s_valid, s_read, s_write, s_addr, busy},
               {4'b0001, 2'b01, 1'b1, 1'b0, 16'h0010, 1'b1});
    end
    s_ready = 2'b01;
    s_rdata = {32'h12345678, 32'hDEADBEEF};
    @(negedge clk);
    checks++;
    if (m_ready !== 4'b0001 || m_rdata !== 32'hDEADBEEF || m_err !== 1'b0 || s_valid !== 2'b00) begin
      errors++;
      $display("FAIL read_resp: m_ready=%b m_rdata=%h m_err=%b s_valid=%b expected 0001 deadbeef 0 00",
               m_ready, m_rdata, m_err, s_valid);
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (m_ready !== '0 || busy !== 1'b0 || grant !== '0 || m_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_after: m_ready=%b busy=%b grant=%b m_rdata=%h expected 0000 0 0000 deadbeef",
               m_ready, busy, grant, m_rdata);
    end
  endtask

  task automatic test_two_masters();
    apply_reset();
    m_valid = 4'b0011; m_write = 4'b0011;
    m_addr[0 +: AW] = 16'h1004;      m_addr[AW +: AW] = 16'h0008;
    m_wdata[0 +: DW] = 32'h11111111; m_wdata[DW +: DW] = 32'h22222222;
    @(negedge clk);
    checks++;
    if ({grant, s_valid, s_write, s_addr, s_wdata} !== {4'b0001, 2'b10, 1'b1, 16'h1004, 32'h11111111}) begin
      errors++;
      $display("FAIL two_first: got %h expected %h", {grant, s_valid, s_write, s_addr, s_wdata},
               {4'b0001, 2'b10, 1'b1, 16'h1004, 32'h11111111});
    end
    s_ready = 2'b10;
    s_rdata = {32'hBBBBBBBB, 32'hAAAAAAAA};
    @(negedge clk);
    checks++;
    if (m_ready !== 4'b0001 || m_err !== 1'b0 || m_rdata !== '0) begin
      errors++;
      $display("FAIL two_first_resp: m_ready=%b m_err=%b m_rdata=%h expected 0001 0 0", m_ready, m_err, m_rdata);
    end
    s_ready = '0;
    m_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (m_ready !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL two_gap: m_ready=%b busy=%b expected 0000 0", m_ready, busy);
    end
    @(negedge clk);
    checks++;
    if ({grant, s_valid, s_addr, s_wdata} !== {4'b0010, 2'b01, 16'h0008, 32'h22222222}) begin
      errors++;
      $display("FAIL two_second: got %h expected %h", {grant, s_valid, s_addr, s_wdata},
               {4'b0010, 2'b01, 16'h0008, 32'h22222222});
    end
    s_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (m_ready !== 4'b0010 || m_err !== 1'b0) begin
      errors++;
      $display("FAIL two_second_resp: m_ready=%b m_err=%b expected 0010 0", m_ready, m_err);
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (m_ready !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL two_end: m_ready=%b busy=%b expected 0000 0", m_ready, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] exp;
    apply_reset();
    m_valid = '1; m_read = '1;
    for (int i = 0; i < NM; i++) m_addr[i*AW +: AW] = {4'(i % 2), 12'(i * 4)};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp = '0;
      exp[k % NM] = 1'b1;
      checks++;
      if (grant !== exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: grant=%b busy=%b expected %b 1", k, grant, busy, exp);
      end
      s_ready = s_valid;
      @(negedge clk);
      checks++;
      if (m_ready !== exp) begin
        errors++;
        $display("FAIL rr_ready%0d: m_ready=%b expected %b", k, m_ready, exp);
      end
      s_ready = '0;
      if (k == 7) m_valid = '0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: busy=%b expected 0", k, busy);
      end
    end
    clear_inputs();
  endtask

  task automatic test_decode_err();
    int unsigned   dm [4] = '{2, 3, 1, 0};
    logic [AW-1:0] da [4] = '{16'hF000, 16'h2000, 16'h0000, 16'h1000};
    logic          dr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic          dw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [NM-1:0] oh;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      oh = '0;
      oh[dm[c]] = 1'b1;
      m_valid = oh;
      m_read[dm[c]] = dr[c];
      m_write[dm[c]] = dw[c];
      m_addr[dm[c]*AW +: AW] = da[c];
      @(negedge clk);
      checks++;
      if (s_valid !== '0 || grant !== oh || busy !== 1'b1) begin
        errors++;
        $display("FAIL derr_issue%0d: s_valid=%b grant=%b busy=%b expected 00 %b 1", c, s_valid, grant, busy, oh);
      end
      s_ready = '1;
      s_rdata = {NS{32'hA5A5A5A5}};
      @(negedge clk);
      checks++;
      if (m_ready !== oh || m_err !== 1'b1 || m_rdata !== '0) begin
        errors++;
        $display("FAIL derr_resp%0d: m_ready=%b m_err=%b m_rdata=%h expected %b 1 0", c, m_ready, m_err, m_rdata, oh);
      end
      clear_inputs();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL derr_idle%0d: busy=%b expected 0", c, busy);
      end
    end
  endtask

  task automatic test_timeout();
    clear_inputs();
    m_valid = 4'b0010; m_write = 4'b0010;
    m_addr[AW +: AW] = 16'h1000;
    m_wdata[DW +: DW] = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if (s_wdata !== 32'h0BADF00D || s_write !== 1'b1) begin
      errors++;
      $display("FAIL to_issue: s_wdata=%h s_write=%b expected 0badf00d 1", s_wdata, s_write);
    end
    s_ready = 2'b01;
    s_rdata = {32'h77777777, 32'h66666666};
    for (int k = 1; k <= TO; k++) begin
      checks++;
      if (s_valid !== 2'b10 || m_ready !== '0) begin
        errors++;
        $display("FAIL to_wait%0d: s_valid=%b m_ready=%b expected 10 0000", k, s_valid, m_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (m_ready !== 4'b0010 || m_err !== 1'b1 || m_rdata !== '0 || s_valid !== '0) begin
      errors++;
      $display("FAIL to_resp: m_ready=%b m_err=%b m_rdata=%h s_valid=%b expected 0010 1 0 00",
               m_ready, m_err, m_rdata, s_valid);
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_ready !== '0) begin
      errors++;
      $display("FAIL to_idle: busy=%b m_ready=%b expected 0 0000", busy, m_ready);
    end
  endtask

  task automatic test_reset_mid_xfer();
    clear_inputs();
    m_valid = 4'b1000; m_read = 4'b1000; m_addr[3*AW +: AW] = 16'h0020;
    @(negedge clk);
    checks++;
    if (s_valid !== 2'b01 || grant !== 4'b1000) begin
      errors++;
      $display("FAIL rmid_issue: s_valid=%b grant=%b expected 01 1000", s_valid, grant);
    end
    m_valid = 4'b1001; m_read = 4'b1001; m_addr[0 +: AW] = 16'h1040;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_valid !== '0 || grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_abort: s_valid=%b grant=%b busy=%b expected 00 0000 0", s_valid, grant, busy);
    end
    @(negedge clk);
    checks++;
    if (m_ready !== '0) begin
      errors++;
      $display("FAIL rmid_noready: m_ready=%b expected 0000", m_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || s_valid !== 2'b10) begin
      errors++;
      $display("FAIL rmid_first: grant=%b s_valid=%b expected 0001 10", grant, s_valid);
    end
    s_ready = 2'b10;
    s_rdata = {32'h600DCAFE, 32'h0};
    @(negedge clk);
    checks++;
    if (m_ready !== 4'b0001 || m_rdata !== 32'h600DCAFE || m_err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_resp: m_ready=%b m_rdata=%h m_err=%b expected 0001 600dcafe 0", m_ready, m_rdata, m_err);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  // Randomized traffic against a transaction-level model: rotating-priority
  // winner, decode rules, slave response time and timeout budget.
  task automatic test_random();
    int unsigned   ptr, win, sel, delay, ntxn, guard, r, c;
    logic [NM-1:0] pend, rd, wr, exp_gnt;
    logic [AW-1:0] ad [NM];
    logic [DW-1:0] wd [NM];
    logic [DW-1:0] last_rd, exp_rd;
    logic          last_err, exp_err;
    logic [NS-1:0] exp_sv, noise;
    bit            derr, done, found;
    apply_reset();
    ptr = NM - 1; pend = '0; rd = '0; wr = '0;
    last_rd = '0; last_err = 1'b0; ntxn = 0; guard = 0;
    for (int i = 0; i < NM; i++) begin ad[i] = '0; wd[i] = '0; end
    while (ntxn < 60 && guard < 3000) begin
      guard++;
      checks++;
      if (busy !== 1'b0 || grant !== '0 || m_ready !== '0 || m_rdata !== last_rd || m_err !== last_err) begin
        errors++;
        $display("FAIL rnd_idle: busy=%b grant=%b m_ready=%b m_rdata=%h m_err=%b expected 0 0000 0000 %h %b",
                 busy, grant, m_ready, m_rdata, m_err, last_rd, last_err);
      end
      for (int i = 0; i < NM; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          r = $urandom_range(0, 15);
          rd[i] = (r < 7) || (r == 14);
          wr[i] = (r >= 7 && r < 14) || (r == 14);
          ad[i] = AW'($urandom);
          r = $urandom_range(0, 7);
          ad[i][15:12] = (r < 3) ? 4'd0 : (r < 6) ? 4'd1 : (r == 6) ? 4'd2 : 4'hF;
          wd[i] = $urandom;
        end
      end
      m_valid = pend; m_read = rd; m_write = wr;
      for (int i = 0; i < NM; i++) begin
        m_addr[i*AW +: AW] = ad[i];
        m_wdata[i*DW +: DW] = wd[i];
      end
      if (pend == '0) begin
        @(negedge clk);
        continue;
      end
      found = 1'b0; win = 0;
      for (int k = 1; k <= NM; k++) begin
        c = (ptr + k) % NM;
        if (!found && pend[c]) begin found = 1'b1; win = c; end
      end
      sel = 32'(ad[win][15:12]);
      derr = (sel >= NS) || (rd[win] == wr[win]);
      r = $urandom_range(0, 9);
      delay = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? TO - 1 : 1000;
      exp_gnt = '0; exp_gnt[win] = 1'b1;
      exp_sv = '0; if (!derr) exp_sv[sel] = 1'b1;
      @(negedge clk);
      checks++;
      if ({grant, busy, s_read, s_write, s_addr, s_wdata} !== {exp_gnt, 1'b1, rd[win], wr[win], ad[win], wd[win]}) begin
        errors++;
        $display("FAIL rnd_issue: got %h expected %h", {grant, busy, s_read, s_write, s_addr, s_wdata},
                 {exp_gnt, 1'b1, rd[win], wr[win], ad[win], wd[win]});
      end
      done = 1'b0; exp_err = 1'b0; exp_rd = '0;
      for (int w = 0; w < TO && !done; w++) begin
        checks++;
        if (s_valid !== exp_sv || m_ready !== '0) begin
          errors++;
          $display("FAIL rnd_xfer: s_valid=%b m_ready=%b expected %b 0000 at wait %0d", s_valid, m_ready, exp_sv, w);
        end
        noise = NS'($urandom);
        s_rdata = {$urandom, $urandom};
        if (derr) begin
          done = 1'b1; exp_err = 1'b1;
        end else if (w == delay) begin
          noise[sel] = 1'b1; done = 1'b1;
          exp_rd = rd[win] ? s_rdata[sel*DW +: DW] : '0;
        end else begin
          noise[sel] = 1'b0;
          if (w == TO - 1) begin done = 1'b1; exp_err = 1'b1; end
        end
        s_ready = noise;
        m_valid[win] = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      checks++;
      if (m_ready !== exp_gnt || m_rdata !== exp_rd || m_err !== exp_err || s_valid !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rnd_resp: m_ready=%b m_rdata=%h m_err=%b s_valid=%b busy=%b expected %b %h %b 00 1",
                 m_ready, m_rdata, m_err, s_valid, busy, exp_gnt, exp_rd, exp_err);
      end
      last_rd = exp_rd; last_err = exp_err;
      pend[win] = 1'b0; ptr = win; ntxn++;
      s_ready = '0;
      m_valid = pend;
      @(negedge clk);
    end
    checks++;
    if (ntxn < 60) begin
      errors++;
      $display("FAIL rnd_progress: completed %0d transactions expected 60", ntxn);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_two_masters();
    test_round_robin();
    test_decode_err();
    test_timeout();
    test_reset_mid_xfer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
